// File: rtl/mcu_control_sequencer.sv
// ============================================================================
//  mcu_control_sequencer -- instruction sequencer and accumulator datapath
//  that feeds the 12-bit MCU ALU and writes its result back.
//  Rev 1.0
// ============================================================================
`default_nettype none

module mcu_control_sequencer #(
  parameter int PC_WIDTH    = 8,
  parameter int DADDR_WIDTH = 4,
  parameter int RESET_PC    = 0
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  output logic [PC_WIDTH-1:0]    ProgAddr,
  input  logic [11:0]            ProgData,
  output logic [DADDR_WIDTH-1:0] DataAddr,
  input  logic [7:0]             DataRdata,
  output logic [7:0]             DataWdata,
  output logic                   DataWe,
  output logic                   AluEnable,
  output logic [7:0]             AluOperand1,
  output logic [7:0]             AluOperand2,
  output logic [3:0]             AluMode,
  output logic [3:0]             AluCflags,
  input  logic [7:0]             AluResult,
  input  logic [3:0]             AluFlags,
  output logic [7:0]             Acc,
  output logic [3:0]             Flags,
  output logic                   Halted
);

  localparam logic [PC_WIDTH-1:0] RESET_PC_V = PC_WIDTH'(RESET_PC);

  localparam logic [3:0] OP_JMP  = 4'b0001;
  localparam logic [3:0] OP_JZ   = 4'b0010;
  localparam logic [3:0] OP_JC   = 4'b0011;
  localparam logic [3:0] OP_ALU  = 4'b0100;
  localparam logic [3:0] OP_LDI  = 4'b0101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEMRD  = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [PC_WIDTH-1:0] pc;
  logic [7:0]          ir;
  logic [7:0]          mdr;
  logic [7:0]          acc;
  logic [3:0]          flag_reg;

  logic [3:0] opcode;
  logic       jump_taken;
  logic       is_store;
  logic       keep_flags;

  assign opcode = ProgData[11:8];
  // Branches see the flag register as already updated by the preceding EXEC.
  assign jump_taken = (opcode == OP_JMP) ||
                      ((opcode == OP_JZ) && flag_reg[3]) ||
                      ((opcode == OP_JC) && flag_reg[2]);
  assign is_store   = (ir[7:4] == 4'b0010);
  assign keep_flags = (ir[7:5] == 3'b001);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_FETCH;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    DataAddr  = '0;
    DataWe    = 1'b0;
    AluEnable = 1'b0;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_ALU: begin
            state_nxt = S_MEMRD;
            DataAddr  = DADDR_WIDTH'(ProgData[3:0]);
          end
          OP_HALT: state_nxt = S_HALT;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_MEMRD:  state_nxt = S_EXEC;
      S_EXEC: begin
        AluEnable = 1'b1;
        if (is_store) begin
          DataWe   = 1'b1;
          DataAddr = DADDR_WIDTH'(ir[3:0]);
        end
        state_nxt = S_FETCH;
      end
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc       <= RESET_PC_V;
      ir       <= '0;
      mdr      <= '0;
      acc      <= '0;
      flag_reg <= '0;
    end else begin
      case (state)
        S_DECODE: begin
          pc <= jump_taken ? PC_WIDTH'(ProgData[7:0]) : pc + PC_WIDTH'(1);
          if (opcode == OP_ALU) ir  <= ProgData[7:0];
          if (opcode == OP_LDI) acc <= ProgData[7:0];
        end
        S_MEMRD: mdr <= DataRdata;
        S_EXEC: begin
          if (!is_store)   acc      <= AluResult;
          if (!keep_flags) flag_reg <= AluFlags;
        end
        default: ;
      endcase
    end
  end

  assign ProgAddr    = pc;
  assign DataWdata   = AluResult;
  assign AluOperand1 = acc;
  assign AluOperand2 = mdr;
  assign AluMode     = ir[7:4];
  assign AluCflags   = flag_reg;
  assign Acc         = acc;
  assign Flags       = flag_reg;
  assign Halted      = (state == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_mcu_control_sequencer.sv
// ============================================================================
//  tb_mcu_control_sequencer -- directed bench with program/data memory and a
//  small ALU model around the sequencer.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_mcu_control_sequencer;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic [7:0]  ProgAddr;
  logic [11:0] ProgData;
  logic [3:0]  DataAddr;
  logic [7:0]  DataRdata;
  logic [7:0]  DataWdata;
  logic        DataWe;
  logic        AluEnable;
  logic [7:0]  AluOperand1;
  logic [7:0]  AluOperand2;
  logic [3:0]  AluMode;
  logic [3:0]  AluCflags;
  logic [7:0]  AluResult;
  logic [3:0]  AluFlags;
  logic [7:0]  Acc;
  logic [3:0]  Flags;
  logic        Halted;

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] prog [256];
  logic [7:0]  dmem [16];
  int          wr_count = 0;
  logic [3:0]  wr_addr  = '0;
  logic [7:0]  wr_data  = '0;

  mcu_control_sequencer dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .ProgAddr(ProgAddr), .ProgData(ProgData),
    .DataAddr(DataAddr), .DataRdata(DataRdata), .DataWdata(DataWdata), .DataWe(DataWe),
    .AluEnable(AluEnable), .AluOperand1(AluOperand1), .AluOperand2(AluOperand2),
    .AluMode(AluMode), .AluCflags(AluCflags), .AluResult(AluResult), .AluFlags(AluFlags),
    .Acc(Acc), .Flags(Flags), .Halted(Halted)
  );

  always #5 Clk = ~Clk;

  // Synchronous-read memories; stores are recorded rather than written back.
  always @(posedge Clk) begin
    ProgData  <= prog[ProgAddr];
    DataRdata <= dmem[DataAddr];
    if (DataWe) begin
      wr_count <= wr_count + 1;
      wr_addr  <= DataAddr;
      wr_data  <= DataWdata;
    end
  end

  // ALU model: 0 add, 1 sub, 2 pass operand1, 3 compare, else xor. Flags {Z,C,S,O}.
  always_comb begin
    logic [8:0] wide;
    wide = 9'd0;
    case (AluMode)
      4'd0:    wide = {1'b0, AluOperand1} + {1'b0, AluOperand2};
      4'd1:    wide = {1'b0, AluOperand1} - {1'b0, AluOperand2};
      4'd2:    wide = {1'b0, AluOperand1};
      4'd3:    wide = {1'b0, AluOperand1} - {1'b0, AluOperand2};
      default: wide = {1'b0, AluOperand1 ^ AluOperand2};
    endcase
    AluResult = wide[7:0];
    AluFlags  = {(wide[7:0] == 8'd0), wide[8], wide[7],
                 (AluMode == 4'd0) && (AluOperand1[7] == AluOperand2[7]) && (wide[7] != AluOperand1[7])};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  initial begin
    int halt_bad;
    int wr_before;
    for (int i = 0; i < 256; i++) prog[i] = 12'h000;
    for (int i = 0; i < 16; i++)  dmem[i] = 8'h00;
    dmem[5]  = 8'h10;
    dmem[6]  = 8'h01;
    dmem[10] = 8'h5A;

    prog[8'h00] = 12'h53C;  prog[8'h01] = 12'h405;  prog[8'h02] = 12'h577;
    prog[8'h03] = 12'h429;  prog[8'h04] = 12'h5FF;  prog[8'h05] = 12'h406;
    prog[8'h06] = 12'h240;  prog[8'h40] = 12'h350;  prog[8'h50] = 12'h501;
    prog[8'h51] = 12'h405;  prog[8'h52] = 12'h260;  prog[8'h53] = 12'h7AB;
    prog[8'h54] = 12'h1FF;  prog[8'hFF] = 12'h000;

    #1 Reset_n = 1'b0;
    #1;
    check("rst_pc", ProgAddr, 8'h00);
    check("rst_acc", Acc, 8'h00);
    check("rst_flags", Flags, 4'h0);
    check("rst_ctl", {DataWe, AluEnable, Halted}, 3'b000);
    @(negedge Clk);
    Reset_n = 1'b1;

    step(2);
    check("ldi_acc", Acc, 8'h3C);
    check("ldi_flags", Flags, 4'h0);
    check("ldi_pc", ProgAddr, 8'h01);

    step(1); check("add_en_dec", AluEnable, 1'b0);
    step(1); check("add_en_mrd", AluEnable, 1'b0);
    step(1); check("add_en_exe", AluEnable, 1'b1);
    check("add_op2", AluOperand2, 8'h10);
    step(1); check("add_en_after", AluEnable, 1'b0);
    check("add_acc", Acc, 8'h4C);
    check("add_flags", Flags, 4'h0);
    check("add_pc", ProgAddr, 8'h02);

    step(2); check("ldi77_acc", Acc, 8'h77);
    step(3);
    check("st_we", DataWe, 1'b1);
    check("st_addr", DataAddr, 4'h9);
    check("st_wdata", DataWdata, 8'h77);
    step(1);
    check("st_we_off", DataWe, 1'b0);
    check("st_count", wr_count, 1);
    check("st_mem", {wr_addr, wr_data}, {4'h9, 8'h77});
    check("st_acc", Acc, 8'h77);
    check("st_flags", Flags, 4'h0);
    check("st_pc", ProgAddr, 8'h04);

    step(2);
    step(4);
    check("addz_acc", Acc, 8'h00);
    check("addz_flags", Flags, 4'hC);
    step(2); check("jz_taken", ProgAddr, 8'h40);
    step(2); check("jc_taken", ProgAddr, 8'h50);
    step(2);
    step(4); check("add2_acc", Acc, 8'h11);
    check("add2_flags", Flags, 4'h0);
    step(2); check("jz_not", ProgAddr, 8'h53);
    step(2); check("undef_pc", ProgAddr, 8'h54);
    check("undef_acc", Acc, 8'h11);
    step(2); check("jmp_ff", ProgAddr, 8'hFF);
    step(2); check("nop_wrap", ProgAddr, 8'h00);

    do_reset();
    prog[8'h00] = 12'h1FF;
    prog[8'hFF] = 12'h100;
    step(2); check("jmp_to_ff", ProgAddr, 8'hFF);
    step(2); check("jmp_wrap", ProgAddr, 8'h00);

    do_reset();
    prog[8'h00] = 12'hF00;
    step(2);
    check("halted", Halted, 1'b1);
    check("halt_pc", ProgAddr, 8'h01);
    halt_bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (DataWe || AluEnable || !Halted || ProgAddr != 8'h01) halt_bad++;
    end
    check("halt_hold", halt_bad, 0);

    do_reset();
    prog[8'h00] = 12'h533;
    prog[8'h01] = 12'h42A;
    step(2);
    wr_before = wr_count;
    step(3);
    check("rst_st_we", DataWe, 1'b1);
    #2 Reset_n = 1'b0;
    #1;
    check("rst_mid_ctl", {DataWe, AluEnable, Halted}, 3'b000);
    check("rst_mid_acc", Acc, 8'h00);
    check("rst_mid_pc", ProgAddr, 8'h00);
    check("rst_mid_flags", Flags, 4'h0);
    step(1);
    check("rst_mid_nowr", wr_count, wr_before);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mcu_control_sequencer.md
Name: mcu_control_sequencer

Overview:
- Instruction sequencer and accumulator datapath that sits directly upstream of the 12-bit microcontroller ALU.
- Fetches 12-bit instructions from program memory and reads operands from data memory.
- Drives the ALU's Enable/Operand1/Operand2/Mode/Cflags inputs, then writes the ALU Result back to the accumulator or data memory.
- Holds the flag register {Z,C,S,O}, captured from the ALU Flags output.

Parameters:
PC_WIDTH, 8, program counter / program address width
DADDR_WIDTH, 4, data memory address width (instruction field I[3:0])
RESET_PC, 0, PC value loaded on reset

Ports:
Clk  input  1  system clock, rising edge
Reset_n  input  1  asynchronous active-low reset
ProgAddr  output  8  program memory address (= PC register)
ProgData  input  12  program memory read data; synchronous read, valid 1 cycle after ProgAddr
DataAddr  output  4  data memory address
DataRdata  input  8  data memory read data; synchronous read, valid 1 cycle after DataAddr
DataWdata  output  8  data memory write data
DataWe  output  1  data memory write enable, 1-cycle pulse
AluEnable  output  1  ALU enable; high only in EXEC
AluOperand1  output  8  accumulator value
AluOperand2  output  8  MDR (latched memory operand)
AluMode  output  4  ALU mode = IR[7:4]
AluCflags  output  4  current flag register
AluResult  input  8  ALU combinational result
AluFlags  input  4  ALU combinational flags {Z,C,S,O}
Acc  output  8  accumulator (debug)
Flags  output  4  flag register (debug)
Halted  output  1  high while in HALT state

Behaviour:
- Instruction decode by I[11:8]:
  - 0000 NOP
  - 0001 JMP I[7:0]
  - 0010 JZ I[7:0] (taken if Flags[3]=1)
  - 0011 JC I[7:0] (taken if Flags[2]=1)
  - 0100 ALU-M: mode I[7:4], data address I[3:0]
  - 0101 LDI: Acc <= I[7:0]
  - 1111 HALT
  - All other encodings execute as NOP.
- States: FETCH, DECODE, MEMRD, EXEC, HALT. State register and all listed registers are async-reset.
- FETCH: ProgAddr = PC. Next state DECODE.
- DECODE: decode ProgData directly. PC <= PC+1 (mod 256) unless a jump is taken, in which case PC <= I[7:0].
  - ALU-M: IR <= ProgData; DataAddr = ProgData[3:0]; next state MEMRD.
  - LDI: Acc <= I[7:0]; flags unchanged; next state FETCH.
  - HALT: next state HALT.
  - Others: next state FETCH.
- MEMRD: MDR <= DataRdata. Next state EXEC.
- EXEC: AluEnable = 1; operands and mode are stable for the whole cycle.
  - If IR[7:4] = 0010: DataWe = 1, DataAddr = IR[3:0], DataWdata = AluResult; Acc and Flags unchanged.
  - Otherwise: Acc <= AluResult.
  - Flags <= AluFlags for every mode except 0010 and 0011.
  - Next state FETCH.
- Latency: ALU-M takes 4 cycles; NOP/JMP/JZ/JC/LDI take 2 cycles.
- HALT: absorbing state. PC frozen, DataWe = 0, AluEnable = 0, Halted = 1. Exits only via reset.
- Branch conditions use the flag register value at the DECODE edge; flags written by the preceding EXEC are already visible.
- PC wrap: PC 0xFF increments to 0x00. JMP to the current address loops forever without error.
- Outside the states above, DataAddr = 0, DataWe = 0, AluEnable = 0.
- Reset values: PC = RESET_PC, ProgAddr = RESET_PC, IR = 0, MDR = 0, Acc = 0, Flags = 0, DataWe = 0, AluEnable = 0, Halted = 0, state = FETCH.
- Reset asserted mid-instruction (including EXEC): DataWe and AluEnable drop immediately and asynchronously; the pending write-back is discarded.
- After Reset_n deasserts, the first FETCH occurs on the first rising edge.

Test Plan:
- Reset, then prog[0] = 0x5_3C (LDI 0x3C) -> after 2 cycles Acc = 0x3C, Flags = 0, PC = 1.
- mem[5] = 0x10, Acc = 0x3C; prog = 0x4_05 (ADD mode 0, addr 5) -> AluEnable high exactly 1 cycle (4th); Acc = 0x4C; Flags = AluFlags captured; PC advances by 1.
- Acc = 0x77, prog = 0x4_29 (mode 0010, addr 9) -> DataWe 1-cycle pulse with DataAddr = 9, DataWdata = 0x77; Acc and Flags unchanged.
- Flags[3] = 1, JZ 0x40 -> PC = 0x40. Flags[3] = 0 -> PC = PC+1. JMP at 0xFF to 0x00 and a NOP at 0xFF both yield PC = 0x00.
- HALT (0xF00) -> Halted = 1 after 2 cycles; PC holds for 20 cycles; no DataWe or AluEnable activity.
- Assert Reset_n low during EXEC of a store -> DataWe falls before the next edge; mem unchanged; all outputs at reset values.
